// File: rtl/branch_ckpt_stack_pkg.sv
// ---------------------------------------------------------------------------
// branch_ckpt_stack_pkg
// Shared types and sizes for the branch checkpoint stack.
//   DEPTH / B_MASK : checkpoint slots, one-hot branch id and b_mask width
//   N_ALLOC        : checkpoints dispatch may allocate per cycle
//   N_RES          : branch-resolution channels from complete
//   ARCH_REGS      : map-table entries in a snapshot
//   PHYS_REGS      : physical registers (free-list snapshot width)
//   ROB_W / LSQ_W  : ROB and LSQ tail index widths
//   ADDR           : PC width
// ckpt_t carries the free-list snapshot taken at dispatch alongside the
// other recovery state, so one struct describes a whole slot.
// ---------------------------------------------------------------------------
package branch_ckpt_stack_pkg;

    localparam int DEPTH     = 4;
    localparam int B_MASK    = DEPTH;
    localparam int N_ALLOC   = 2;
    localparam int N_RES     = 2;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PHYS_IDX  = $clog2(PHYS_REGS);
    localparam int ROB_W     = 5;
    localparam int LSQ_W     = 4;
    localparam int ADDR      = 32;
    localparam int BP_PKT_W  = 8;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef logic [B_MASK-1:0] b_mask_t;
    typedef logic [ARCH_REGS-1:0][PHYS_IDX-1:0] map_t;

    typedef struct packed {
        logic [ADDR-1:0]      pc;
        logic [ADDR-1:0]      recovery_pc;
        logic                 is_jump;
        logic [ROB_W-1:0]     rob_tail;
        logic [LSQ_W-1:0]     lsq_tail;
        map_t                 map_table;
        logic [PHYS_REGS-1:0] free_list;
        logic [BP_PKT_W-1:0]  bp_packet;
    } ckpt_t;

    typedef struct packed {
        logic                valid;
        logic                is_branch;
        logic [ADDR-1:0]     pc;
        logic [ADDR-1:0]     target;
        logic                taken;
        logic [BP_PKT_W-1:0] bp_packet;
    } bp_update_t;

    // Population count of a slot mask, sized to hold 0..DEPTH.
    function automatic logic [CNT_W-1:0] count_ones(input b_mask_t m);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < B_MASK; i++) begin
            n = n + CNT_W'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_ckpt_stack_if.sv
// ---------------------------------------------------------------------------
// branch_ckpt_stack_if
// Bundles the dispatch, complete and recovery signals of the checkpoint
// stack. The slave modport is the stack itself; master is its environment
// (dispatch, complete, retire on the input side; fetch/ROB/LSQ/free list
// and the branch predictor on the output side).
//   alloc_req/alloc_ckpt -> alloc_gnt/alloc_id   : checkpoint allocation
//   free_slots, live_mask                        : occupancy status
//   freed_regs                                   : retire-freed registers
//   res_*                                        : branch resolution
//   restore_*, squash_mask, resolved_mask        : recovery broadcast
//   bp_update                                    : predictor training
// ---------------------------------------------------------------------------
interface branch_ckpt_stack_if;
    import branch_ckpt_stack_pkg::*;

    logic [N_ALLOC-1:0]            alloc_req;
    ckpt_t [N_ALLOC-1:0]           alloc_ckpt;
    logic [N_ALLOC-1:0]            alloc_gnt;
    b_mask_t [N_ALLOC-1:0]         alloc_id;
    logic [CNT_W-1:0]              free_slots;
    b_mask_t                       live_mask;
    logic [PHYS_REGS-1:0]          freed_regs;
    logic [N_RES-1:0]              res_valid;
    b_mask_t [N_RES-1:0]           res_id;
    logic [N_RES-1:0]              res_mispred;
    logic [N_RES-1:0]              res_taken;
    logic [N_RES-1:0][ADDR-1:0]    res_target;
    logic                          restore_valid;
    logic [ADDR-1:0]               restore_pc;
    logic [ROB_W-1:0]              restore_rob_tail;
    logic [LSQ_W-1:0]              restore_lsq_tail;
    map_t                          restore_map;
    logic [PHYS_REGS-1:0]          restore_free;
    b_mask_t                       squash_mask;
    b_mask_t                       resolved_mask;
    bp_update_t [N_RES-1:0]        bp_update;

    modport slave (
        input  alloc_req, alloc_ckpt, freed_regs,
               res_valid, res_id, res_mispred, res_taken, res_target,
        output alloc_gnt, alloc_id, free_slots, live_mask,
               restore_valid, restore_pc, restore_rob_tail, restore_lsq_tail,
               restore_map, restore_free, squash_mask, resolved_mask, bp_update
    );

    modport master (
        output alloc_req, alloc_ckpt, freed_regs,
               res_valid, res_id, res_mispred, res_taken, res_target,
        input  alloc_gnt, alloc_id, free_slots, live_mask,
               restore_valid, restore_pc, restore_rob_tail, restore_lsq_tail,
               restore_map, restore_free, squash_mask, resolved_mask, bp_update
    );

endinterface

// File: rtl/branch_ckpt_stack_oldest_sel.sv
// ---------------------------------------------------------------------------
// branch_ckpt_stack_oldest_sel
// Picks the oldest id out of a candidate mask. A slot's dep mask lists every
// slot older than it, so the oldest candidate is the one whose dep holds no
// other candidate.
//   cand   : candidate ids (one bit per slot)
//   dep    : per-slot mask of older live slots
//   oldest : one-hot oldest candidate, zero when cand is zero
// ---------------------------------------------------------------------------
module branch_ckpt_stack_oldest_sel
    import branch_ckpt_stack_pkg::*;
(
    input  b_mask_t                 cand,
    input  b_mask_t [DEPTH-1:0]     dep,
    output b_mask_t                 oldest
);

    // A candidate wins when none of its elders are also candidates.
    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = cand[i] && ((dep[i] & cand) == '0);
        end
    end

endmodule

// File: rtl/branch_ckpt_stack.sv
// ---------------------------------------------------------------------------
// branch_ckpt_stack
// Branch checkpoint stack between dispatch, complete, fetch, ROB, LSQ and the
// free list. Allocates up to N_ALLOC checkpoints per cycle, resolves up to
// N_RES branches per cycle and, on a mispredict, restores from the oldest
// mispredicting branch in the same cycle while squashing everything younger.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : branch_ckpt_stack_if.slave (allocation, resolution,
//                  restore, squash/resolved broadcast, bp_update)
//   perf_cnt     : [0] resolves, [1] mispredicts, [2] full-stall cycles;
//                  32-bit saturating, present only with BCS_PERF_CNT_EN
// Optional feature macro: BCS_PERF_CNT_EN
// ---------------------------------------------------------------------------
module branch_ckpt_stack
    import branch_ckpt_stack_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
`ifdef BCS_PERF_CNT_EN
    output logic [2:0][31:0]          perf_cnt,
`endif
    branch_ckpt_stack_if.slave        bus
);

    b_mask_t                 live_q;
    ckpt_t   [DEPTH-1:0]     slot_q;
    b_mask_t [DEPTH-1:0]     dep_q;

    logic [N_RES-1:0]            eff;
    logic [N_RES-1:0]            mis;
    logic [N_RES-1:0]            ch_is_jump;
    logic [N_RES-1:0][ADDR-1:0]  ch_rpc;
    logic [N_RES-1:0][ADDR-1:0]  ch_pc;
    logic [N_RES-1:0][BP_PKT_W-1:0] ch_bp;
    b_mask_t                     eff_ids;
    b_mask_t                     mis_ids;
    b_mask_t                     winner;
    b_mask_t                     squash;
    b_mask_t                     resolved;
    logic                        restore_valid;

    logic                        win_found;
    logic                        win_taken;
    logic [ADDR-1:0]             win_target;
    logic                        w_is_jump;
    logic [ADDR-1:0]             w_rpc;
    logic [ROB_W-1:0]            w_rob;
    logic [LSQ_W-1:0]            w_lsq;
    map_t                        w_map;
    logic [PHYS_REGS-1:0]        w_free;

    logic [N_ALLOC-1:0]          gnt;
    b_mask_t [N_ALLOC-1:0]       gnt_id;
    b_mask_t [N_ALLOC-1:0]       lane_dep;
    b_mask_t                     slot_alloc;
    ckpt_t   [DEPTH-1:0]         slot_new;
    b_mask_t [DEPTH-1:0]         slot_new_dep;
    bp_update_t [N_RES-1:0]      bp;
    logic [CNT_W-1:0]            free_cnt;

    // Look up each resolving channel's slot and decide whether it is live
    // (effective) and whether it mispredicts. A jump whose computed target
    // differs from the predicted recovery PC counts as a mispredict too.
    always_comb begin
        eff        = '0;
        mis        = '0;
        ch_is_jump = '0;
        ch_rpc     = '0;
        ch_pc      = '0;
        ch_bp      = '0;
        eff_ids    = '0;
        mis_ids    = '0;
        for (int c = 0; c < N_RES; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.res_id[c][i]) begin
                    ch_is_jump[c] = slot_q[i].is_jump;
                    ch_rpc[c]     = slot_q[i].recovery_pc;
                    ch_pc[c]      = slot_q[i].pc;
                    ch_bp[c]      = slot_q[i].bp_packet;
                end
            end
            eff[c] = bus.res_valid[c] && ((bus.res_id[c] & live_q) != '0);
            mis[c] = eff[c] && (bus.res_mispred[c] ||
                     (ch_is_jump[c] && (bus.res_target[c] != ch_rpc[c])));
            if (eff[c]) eff_ids = eff_ids | (bus.res_id[c] & live_q);
            if (mis[c]) mis_ids = mis_ids | (bus.res_id[c] & live_q);
        end
    end

    branch_ckpt_stack_oldest_sel u_oldest_sel (
        .cand   (mis_ids),
        .dep    (dep_q),
        .oldest (winner)
    );

    assign restore_valid = |winner;

    // Gather the restore payload: direction/target from the first channel
    // naming the winner, recovery state from the winner's slot. Everything
    // stays zero when no restore fires.
    always_comb begin
        win_found  = 1'b0;
        win_taken  = 1'b0;
        win_target = '0;
        for (int c = 0; c < N_RES; c++) begin
            if (!win_found && mis[c] && ((bus.res_id[c] & winner) != '0)) begin
                win_found  = 1'b1;
                win_taken  = bus.res_taken[c];
                win_target = bus.res_target[c];
            end
        end
        w_is_jump = 1'b0;
        w_rpc     = '0;
        w_rob     = '0;
        w_lsq     = '0;
        w_map     = '0;
        w_free    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (winner[i]) begin
                w_is_jump = slot_q[i].is_jump;
                w_rpc     = slot_q[i].recovery_pc;
                w_rob     = slot_q[i].rob_tail;
                w_lsq     = slot_q[i].lsq_tail;
                w_map     = slot_q[i].map_table;
                w_free    = slot_q[i].free_list;
            end
        end
    end

    // Squash the winner and every live slot that depends on it. Correct
    // resolutions among the squashed slots are dropped; the rest, plus the
    // winner, are broadcast as resolved.
    always_comb begin
        squash = winner;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && ((dep_q[i] & winner) != '0)) squash[i] = 1'b1;
        end
        resolved = (eff_ids & ~squash) | winner;
    end

    // Predictor training: every effective channel except those killed by an
    // older winner. The winner itself still trains.
    always_comb begin
        bp = '0;
        for (int c = 0; c < N_RES; c++) begin
            if (eff[c] && ((bus.res_id[c] & squash & ~winner) == '0)) begin
                bp[c].valid     = 1'b1;
                bp[c].is_branch = !ch_is_jump[c];
                bp[c].pc        = ch_pc[c];
                bp[c].target    = bus.res_target[c];
                bp[c].taken     = bus.res_taken[c];
                bp[c].bp_packet = ch_bp[c];
            end
        end
    end

    // In-order allocation: lane k takes the lowest slot still free after the
    // lower lanes, and the first denied lane denies everything above it.
    // Each new slot depends on surviving live slots and the older lanes of
    // this cycle; slots resolving right now are already excluded.
    always_comb begin
        b_mask_t avail;
        b_mask_t older;
        b_mask_t pick;
        logic    lane_ok;
        avail    = ~live_q;
        older    = live_q & ~resolved;
        lane_ok  = !restore_valid && !reset;
        gnt      = '0;
        gnt_id   = '0;
        lane_dep = '0;
        for (int k = 0; k < N_ALLOC; k++) begin
            pick = avail & (~avail + b_mask_t'(1));
            if (lane_ok && bus.alloc_req[k] && (pick != '0)) begin
                gnt[k]      = 1'b1;
                gnt_id[k]   = pick;
                lane_dep[k] = older;
                older       = older | pick;
                avail       = avail & ~pick;
            end else begin
                lane_ok = 1'b0;
            end
        end
    end

    // Route each granted lane to its slot. The stored free list already
    // includes registers retired during the allocation cycle.
    always_comb begin
        slot_alloc   = '0;
        slot_new     = '0;
        slot_new_dep = '0;
        for (int k = 0; k < N_ALLOC; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[k] && gnt_id[k][i]) begin
                    slot_alloc[i]         = 1'b1;
                    slot_new[i]           = bus.alloc_ckpt[k];
                    slot_new[i].free_list = bus.alloc_ckpt[k].free_list | bus.freed_regs;
                    slot_new_dep[i]       = lane_dep[k];
                end
            end
        end
    end

    // Slot state update. New allocations only land on free slots and kills
    // only hit live ones, so the branches never collide. Survivors drop
    // resolved ids from their dep and keep absorbing retire-freed registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            live_q <= '0;
            slot_q <= '0;
            dep_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_alloc[i]) begin
                    live_q[i] <= 1'b1;
                    slot_q[i] <= slot_new[i];
                    dep_q[i]  <= slot_new_dep[i];
                end else if (squash[i] || resolved[i]) begin
                    live_q[i] <= 1'b0;
                end else if (live_q[i]) begin
                    dep_q[i]            <= dep_q[i] & ~resolved;
                    slot_q[i].free_list <= slot_q[i].free_list | bus.freed_regs;
                end
            end
        end
    end

    assign free_cnt              = count_ones(~live_q);
    assign bus.alloc_gnt         = gnt;
    assign bus.alloc_id          = gnt_id;
    assign bus.free_slots        = free_cnt;
    assign bus.live_mask         = live_q;
    assign bus.restore_valid     = restore_valid;
    assign bus.restore_pc        = (win_taken && !w_is_jump) ? w_rpc : win_target;
    assign bus.restore_rob_tail  = w_rob;
    assign bus.restore_lsq_tail  = w_lsq;
    assign bus.restore_map       = w_map;
    assign bus.restore_free      = w_free;
    assign bus.squash_mask       = squash;
    assign bus.resolved_mask     = resolved;
    assign bus.bp_update         = bp;

`ifdef BCS_PERF_CNT_EN
    logic [31:0] cnt_resolve;
    logic [31:0] cnt_mispred;
    logic [31:0] cnt_stall;
    logic [31:0] eff_count;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    // Number of effective resolutions this cycle.
    always_comb begin
        eff_count = '0;
        for (int c = 0; c < N_RES; c++) begin
            eff_count = eff_count + 32'(eff[c]);
        end
    end

    // Saturating event counters; a full stall is dispatch wanting a slot
    // while none are free at the start of the cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_resolve <= '0;
            cnt_mispred <= '0;
            cnt_stall   <= '0;
        end else begin
            cnt_resolve <= sat_add(cnt_resolve, eff_count);
            cnt_mispred <= sat_add(cnt_mispred, 32'(restore_valid));
            cnt_stall   <= sat_add(cnt_stall, 32'(bus.alloc_req[0] && (free_cnt == '0)));
        end
    end

    assign perf_cnt = {cnt_stall, cnt_mispred, cnt_resolve};
`endif

endmodule

// File: tb/tb_branch_ckpt_stack.sv
// ---------------------------------------------------------------------------
// tb_branch_ckpt_stack
// Directed bench for branch_ckpt_stack. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
// Expected values are worked out by hand from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_branch_ckpt_stack;
    import branch_ckpt_stack_pkg::*;

    logic clock;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    branch_ckpt_stack_if bus ();

`ifdef BCS_PERF_CNT_EN
    logic [2:0][31:0] perf_cnt;
`endif

    branch_ckpt_stack dut (
        .clock    (clock),
        .reset    (reset),
`ifdef BCS_PERF_CNT_EN
        .perf_cnt (perf_cnt),
`endif
        .bus      (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    function automatic map_t mk_map(input logic [5:0] tag);
        map_t m;
        for (int r = 0; r < ARCH_REGS; r++) m[r] = tag + 6'(r);
        return m;
    endfunction

    function automatic ckpt_t mk_ckpt(input logic [31:0] pc, input logic [31:0] rpc,
                                      input logic jmp, input logic [4:0] rob,
                                      input logic [3:0] lsq, input logic [5:0] tag,
                                      input logic [63:0] fl);
        ckpt_t c;
        c.pc          = pc;
        c.recovery_pc = rpc;
        c.is_jump     = jmp;
        c.rob_tail    = rob;
        c.lsq_tail    = lsq;
        c.map_table   = mk_map(tag);
        c.free_list   = fl;
        c.bp_packet   = 8'(tag);
        return c;
    endfunction

    // Wait for the falling edge and return every input to idle.
    task automatic apply_stimulus();
        @(negedge clock);
        bus.alloc_req   = '0;
        bus.alloc_ckpt  = '0;
        bus.freed_regs  = '0;
        bus.res_valid   = '0;
        bus.res_id      = '0;
        bus.res_mispred = '0;
        bus.res_taken   = '0;
        bus.res_target  = '0;
    endtask

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        #1;
        check_output("reset_live", bus.live_mask, 4'b0000);
        check_output("reset_free", bus.free_slots, 3'd4);
        check_output("reset_restore", bus.restore_valid, 1'b0);
        check_output("reset_squash", bus.squash_mask, 4'b0000);

        // 1. Two allocations per cycle until full.
        $display("[TB] test 1: fill");
        apply_stimulus();
        bus.alloc_req = 2'b11;
        #1;
        check_output("t1_gnt_a", bus.alloc_gnt, 2'b11);
        check_output("t1_id0_a", bus.alloc_id[0], 4'b0001);
        check_output("t1_id1_a", bus.alloc_id[1], 4'b0010);
        apply_stimulus();
        bus.alloc_req = 2'b11;
        #1;
        check_output("t1_free_b", bus.free_slots, 3'd2);
        check_output("t1_id0_b", bus.alloc_id[0], 4'b0100);
        check_output("t1_id1_b", bus.alloc_id[1], 4'b1000);
        apply_stimulus();
        bus.alloc_req = 2'b11;
        #1;
        check_output("t1_live_full", bus.live_mask, 4'b1111);
        check_output("t1_free_full", bus.free_slots, 3'd0);
        check_output("t1_gnt_full", bus.alloc_gnt, 2'b00);
        apply_stimulus();
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;

        // 2. Mispredict on the middle of three dependent branches.
        $display("[TB] test 2: single mispredict");
        apply_stimulus();
        bus.alloc_req     = 2'b11;
        bus.alloc_ckpt[0] = mk_ckpt(32'h0100, 32'h0200, 1'b0, 5'd2, 4'd1, 6'd1, 64'h0);
        bus.alloc_ckpt[1] = mk_ckpt(32'h1000, 32'h1100, 1'b0, 5'd9, 4'd3, 6'd10, 64'h0);
        apply_stimulus();
        bus.alloc_req     = 2'b01;
        bus.alloc_ckpt[0] = mk_ckpt(32'h1200, 32'h1300, 1'b0, 5'd11, 4'd5, 6'd20, 64'h0);
        #1;
        check_output("t2_id_c", bus.alloc_id[0], 4'b0100);
        apply_stimulus();
        bus.res_valid     = 2'b01;
        bus.res_id[0]     = 4'b0010;
        bus.res_mispred   = 2'b01;
        bus.res_target[0] = 32'h1040;
        bus.alloc_req     = 2'b01;
        #1;
        check_output("t2_restore", bus.restore_valid, 1'b1);
        check_output("t2_pc", bus.restore_pc, 32'h1040);
        check_output("t2_squash", bus.squash_mask, 4'b0110);
        check_output("t2_resolved", bus.resolved_mask, 4'b0010);
        check_output("t2_rob", bus.restore_rob_tail, 5'd9);
        check_output("t2_lsq", bus.restore_lsq_tail, 4'd3);
        check_output("t2_map", bus.restore_map, mk_map(6'd10));
        check_output("t2_gnt_blocked", bus.alloc_gnt, 2'b00);
        apply_stimulus();
        #1;
        check_output("t2_live_after", bus.live_mask, 4'b0001);

        // 3. Two mispredicts in one cycle; the older one wins.
        $display("[TB] test 3: oldest mispredict wins");
        bus.alloc_req     = 2'b11;
        bus.alloc_ckpt[0] = mk_ckpt(32'h3000, 32'h3100, 1'b0, 5'd4, 4'd4, 6'd30, 64'h0);
        bus.alloc_ckpt[1] = mk_ckpt(32'h3200, 32'h3300, 1'b0, 5'd6, 4'd6, 6'd40, 64'h0);
        #1;
        check_output("t3_id0", bus.alloc_id[0], 4'b0010);
        check_output("t3_id1", bus.alloc_id[1], 4'b0100);
        apply_stimulus();
        bus.res_valid     = 2'b11;
        bus.res_id[0]     = 4'b0100;
        bus.res_id[1]     = 4'b0001;
        bus.res_mispred   = 2'b11;
        bus.res_taken     = 2'b10;
        bus.res_target[0] = 32'h5555;
        bus.res_target[1] = 32'h7777;
        #1;
        check_output("t3_squash", bus.squash_mask, 4'b0111);
        check_output("t3_pc", bus.restore_pc, 32'h0200);
        check_output("t3_rob", bus.restore_rob_tail, 5'd2);
        check_output("t3_resolved", bus.resolved_mask, 4'b0001);
        check_output("t3_bp0_valid", bus.bp_update[0].valid, 1'b0);
        check_output("t3_bp1_valid", bus.bp_update[1].valid, 1'b1);
        apply_stimulus();
        #1;
        check_output("t3_live_after", bus.live_mask, 4'b0000);

        // 4. Correct jump resolve with a same-cycle allocation, then a
        //    double mispredict that only resolves correctly if the jump's
        //    id was cleared from the surviving deps.
        $display("[TB] test 4: correct jump");
        bus.alloc_req     = 2'b11;
        bus.alloc_ckpt[0] = mk_ckpt(32'h1FF0, 32'h2000, 1'b1, 5'd1, 4'd1, 6'd50, 64'h0);
        bus.alloc_ckpt[1] = mk_ckpt(32'h2000, 32'h2100, 1'b0, 5'd12, 4'd7, 6'd51, 64'h0);
        apply_stimulus();
        bus.res_valid     = 2'b01;
        bus.res_id[0]     = 4'b0001;
        bus.res_taken     = 2'b01;
        bus.res_target[0] = 32'h2000;
        bus.alloc_req     = 2'b01;
        bus.alloc_ckpt[0] = mk_ckpt(32'h2200, 32'h2300, 1'b0, 5'd13, 4'd8, 6'd52, 64'h0);
        #1;
        check_output("t4_restore", bus.restore_valid, 1'b0);
        check_output("t4_resolved", bus.resolved_mask, 4'b0001);
        check_output("t4_squash", bus.squash_mask, 4'b0000);
        check_output("t4_bp_valid", bus.bp_update[0].valid, 1'b1);
        check_output("t4_bp_is_branch", bus.bp_update[0].is_branch, 1'b0);
        check_output("t4_alloc_id", bus.alloc_id[0], 4'b0100);
        apply_stimulus();
        bus.alloc_req     = 2'b01;
        bus.alloc_ckpt[0] = mk_ckpt(32'h2400, 32'h2500, 1'b0, 5'd14, 4'd9, 6'd53, 64'h0);
        #1;
        check_output("t4_live_mid", bus.live_mask, 4'b0110);
        check_output("t4_reuse_id", bus.alloc_id[0], 4'b0001);
        apply_stimulus();
        bus.res_valid     = 2'b11;
        bus.res_id[0]     = 4'b0001;
        bus.res_id[1]     = 4'b0010;
        bus.res_mispred   = 2'b11;
        bus.res_target[0] = 32'h9999;
        bus.res_target[1] = 32'h4444;
        #1;
        check_output("t4_dep_restore", bus.restore_valid, 1'b1);
        check_output("t4_dep_squash", bus.squash_mask, 4'b0111);
        check_output("t4_dep_pc", bus.restore_pc, 32'h4444);
        check_output("t4_dep_rob", bus.restore_rob_tail, 5'd12);
        check_output("t4_dep_bp0", bus.bp_update[0].valid, 1'b0);
        apply_stimulus();
        #1;
        check_output("t4_live_after", bus.live_mask, 4'b0000);

        // 5. Free-list accumulation, then a stale resolve after the squash.
        $display("[TB] test 5: free list and stale id");
        bus.alloc_req     = 2'b01;
        bus.alloc_ckpt[0] = mk_ckpt(32'h6000, 32'h6100, 1'b0, 5'd7, 4'd2, 6'd60, 64'hFF);
        bus.freed_regs    = 64'h100;
        apply_stimulus();
        bus.freed_regs    = 64'h0000_0020_0000_0000;
        apply_stimulus();
        bus.res_valid     = 2'b01;
        bus.res_id[0]     = 4'b0001;
        bus.res_mispred   = 2'b01;
        bus.res_target[0] = 32'h3000;
        #1;
        check_output("t5_free_snap", bus.restore_free, 64'h0000_0020_0000_01FF);
        check_output("t5_pc", bus.restore_pc, 32'h3000);
        apply_stimulus();
        bus.res_valid     = 2'b01;
        bus.res_id[0]     = 4'b0001;
        bus.res_mispred   = 2'b01;
        bus.res_target[0] = 32'h3000;
        #1;
        check_output("t5_stale_restore", bus.restore_valid, 1'b0);
        check_output("t5_stale_resolved", bus.resolved_mask, 4'b0000);
        check_output("t5_stale_bp", bus.bp_update[0].valid, 1'b0);
        check_output("t5_free_slots", bus.free_slots, 3'd4);

        // 6. Reset asserted while a restore is in flight.
        $display("[TB] test 6: reset mid-restore");
        apply_stimulus();
        bus.alloc_req = 2'b11;
        apply_stimulus();
        bus.res_valid     = 2'b01;
        bus.res_id[0]     = 4'b0001;
        bus.res_mispred   = 2'b01;
        bus.res_target[0] = 32'h6000;
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        #1;
        check_output("t6_live", bus.live_mask, 4'b0000);
        check_output("t6_free", bus.free_slots, 3'd4);
        check_output("t6_restore", bus.restore_valid, 1'b0);
        check_output("t6_pc", bus.restore_pc, 32'h0);
        check_output("t6_squash", bus.squash_mask, 4'b0000);
        check_output("t6_gnt", bus.alloc_gnt, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
